load_store_unit: RTL and testbench

Load/store unit sitting between the RISC-V execute stage and the word-wide `data_mem` block. It accepts one byte, halfword or word load/store request at a time and drives `data_mem`'s word address, read and write enables and write data. Loads are returned sign- or zero-extended. Sub-word stores are done as read-modify-write, because `data_mem` has no byte enables.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide data_mem; sub-word stores are read-modify-write.
// One request in flight: 3 edges for load/SW, 4 for SB/SH, 2 for errors; req_ready only in IDLE.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_data_out
);

  localparam logic [31:0] MemWordsL = 32'(MEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_en_q, mem_read_en_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] req_word;
  logic        f3_ok, misalign, out_of_range, req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext, merged;

  assign req_ready   = (state_q == S_IDLE) && !rst;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_read_en = mem_read_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;

  // Request legality is decided at the accept edge so errors reach RESP directly.
  always_comb begin
    req_word     = {2'b00, req_addr[31:2]};
    f3_ok        = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = req_word >= MemWordsL;
    req_bad      = !f3_ok || misalign || out_of_range;
  end

  always_comb begin
    byte_sel = mem_data_out[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem_data_out;
    endcase
    merged = mem_data_out;
    if (funct3_q[0]) merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else             merged[{off_q, 3'b000} +: 8]       = wdata_q[7:0];
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_read_en_d = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_wr_data_d = 32'h0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d          = req_we;
          funct3_d      = req_funct3;
          off_d         = req_addr[1:0];
          wdata_d       = req_wdata;
          mem_address_d = req_word;
          if (req_bad) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d       = S_LOAD;
            mem_read_en_d = 1'b1;
          end else if (req_funct3 == 3'b010) begin
            state_d       = S_WRITE;
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = req_wdata;
          end else begin
            state_d       = S_RMW_RD;
            mem_read_en_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
        resp_err_d   = 1'b0;
      end
      S_RMW_RD: begin
        state_d       = S_WRITE;
        mem_wr_en_d   = 1'b1;
        mem_wr_data_d = merged;
      end
      S_WRITE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      wdata_q       <= 32'h0;
      mem_address_q <= 32'h0;
      mem_read_en_q <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_read_en_q <= mem_read_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_mem alongside.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_wr_data, mem_data_out;
  logic        mem_read_en, mem_wr_en;

  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_dat;
  logic [7:0]  mem_idx;

  int compared = 0;
  int mismatched = 0;
  int rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, resp_cnt = 0;
  int lat_o, rd_o, wr_o;
  logic [31:0] rdata_o, addr_o;
  logic        err_o, got_o;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  assign mem_idx      = mem_address[7:0];
  assign mem_data_out = mem_read_en ? mem[mem_idx] : 32'h0;

  always @(posedge clk) begin
    if (mem_wr_en)  mem[mem_idx] <= mem_wr_data;
    else if (bd_we) mem[bd_idx] <= bd_dat;
    if (mem_read_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en)   wr_cnt <= wr_cnt + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    if (resp_valid)  resp_cnt <= resp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] dat);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_dat = dat;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issues one request and measures edges from accept to the edge ending resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int edges, rd0, wr0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    addr_o = mem_address;
    got_o = 1'b0;
    while (!got_o && edges < 20) begin
      if (resp_valid) got_o = 1'b1;
      else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    lat_o = edges + 1;
    rdata_o = resp_rdata;
    err_o = resp_err;
    @(posedge clk);
    @(negedge clk);
    rd_o = rd_cnt - rd0;
    wr_o = wr_cnt - wr0;
    check("resp_seen", 32'(got_o), 32'd1);
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err"}, 32'(err_o), 32'd1);
    check({tag, "_rdata"}, rdata_o, 32'h0);
    check({tag, "_lat"}, lat_o, 32'd2);
    check({tag, "_pulses"}, rd_o + wr_o, 32'd0);
  endtask

  initial begin
    int low_cnt, seen_resp, acc0, resp0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; bd_we = 1'b0; bd_idx = 8'h0; bd_dat = 32'h0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp", {29'h0, resp_valid, resp_err, mem_read_en}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wr", {31'h0, mem_wr_en} | mem_wr_data, 32'h0);
    poke(8'd32, 32'h12345678);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    do_req(1'b0, 3'b010, 32'h80, 32'h0);
    check("lw_addr", addr_o, 32'd32);
    check("lw_rdata", rdata_o, 32'h12345678);
    check("lw_err", 32'(err_o), 32'd0);
    check("lw_lat", lat_o, 32'd3);

    poke(8'd32, 32'h0000F080);
    do_req(1'b0, 3'b000, 32'h81, 32'h0);
    check("lb_rdata", rdata_o, 32'hFFFFFFF0);
    do_req(1'b0, 3'b100, 32'h81, 32'h0);
    check("lbu_rdata", rdata_o, 32'h000000F0);
    poke(8'd32, 32'h80010000);
    do_req(1'b0, 3'b001, 32'h82, 32'h0);
    check("lh_rdata", rdata_o, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h82, 32'h0);
    check("lhu_rdata", rdata_o, 32'h00008001);

    do_req(1'b1, 3'b010, 32'h168, 32'd66);
    check("sw_mem", mem[90], 32'h00000042);
    check("sw_lat", lat_o, 32'd3);
    check("sw_rdata", rdata_o, 32'h0);
    check("sw_pulses", {16'(rd_o), 16'(wr_o)}, {16'd0, 16'd1});

    poke(8'd51, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h0CD, 32'hFFFFFF9E);
    check("sb_mem", mem[51], 32'h11229E44);
    check("sb_lat", lat_o, 32'd4);
    check("sb_pulses", {16'(rd_o), 16'(wr_o)}, {16'd1, 16'd1});
    check("sb_err", 32'(err_o), 32'd0);
    do_req(1'b0, 3'b000, 32'h0CD, 32'h0);
    check("lb_reload", rdata_o, 32'hFFFFFF9E);

    poke(8'd51, 32'h11223344);
    do_req(1'b1, 3'b001, 32'h0CE, 32'h0000BEEF);
    check("sh_mem", mem[51], 32'hBEEF3344);

    do_req(1'b0, 3'b010, 32'h2, 32'h0);
    check_err("lw_mis");
    do_req(1'b1, 3'b001, 32'h3, 32'h0);
    check_err("sh_mis");
    do_req(1'b0, 3'b011, 32'h0, 32'h0);
    check_err("f3_ill");
    do_req(1'b0, 3'b010, 32'h400, 32'h0);
    check_err("lw_oor");

    poke(8'd52, 32'hAABBCCDD);
    low_cnt = 0; seen_resp = 0;
    @(negedge clk);
    acc0 = acc_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'hD0; req_wdata = 32'h55;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!req_ready) low_cnt++;
      if (resp_valid) seen_resp++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc_cnt - acc0, 32'd3);
    check("b2b_resps", seen_resp, 32'd3);
    check("b2b_ready_low", low_cnt, 32'd9);
    check("b2b_mem", mem[52], 32'hAABBCC55);

    poke(8'd10, 32'h01020304);
    @(negedge clk);
    resp0 = resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h28; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    check("rst_mid_wr_en", 32'(mem_wr_en), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_wr_drop", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_mem", mem[10], 32'h01020304);
    check("rst_mid_no_resp", resp_cnt - resp0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
